cache_mem_responder: RTL

- Memory-side responder for the cache request interface: services one dcache port (read/write) and one icache port (read-only).
- Arbitrates the two ports onto a single RAM request/acknowledge port.
- Signals completion by dropping the port's wait line for exactly one cycle, with read data valid in that cycle.
- Sits between the caches and RAM. This is the far end of the dREN/dWEN/daddr/dstore/dwait/dload handshake that the dcache initiates.

---
 rtl/cache_mem_responder.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the dcache/icache request ports.
// Arbitrates both ports onto one RAM req/ack port with a timeout abort.
module cache_mem_responder #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    output logic              ram_req,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        DSERV,
        ISERV,
        DRESP,
        IRESP
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic              r_last_d, w_last_d_nxt;
    logic              r_dwait, w_dwait_nxt;
    logic              r_iwait, w_iwait_nxt;
    logic [DATA_W-1:0] r_dload, w_dload_nxt;
    logic [DATA_W-1:0] r_iload, w_iload_nxt;
    logic              r_req, w_req_nxt;
    logic              r_wen, w_wen_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic              r_err, w_err_nxt;

    logic w_dreq, w_grant_d, w_grant_i, w_tmo;

    assign w_dreq    = dREN | dWEN;
    // When both ports ask, the port not served last wins.
    assign w_grant_d = w_dreq & (~iREN | ~r_last_d);
    assign w_grant_i = iREN & (~w_dreq | r_last_d);
    assign w_tmo     = (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_last_d <= 1'b0;
            r_dwait  <= 1'b1;
            r_iwait  <= 1'b1;
            r_dload  <= '0;
            r_iload  <= '0;
            r_req    <= 1'b0;
            r_wen    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_last_d <= w_last_d_nxt;
            r_dwait  <= w_dwait_nxt;
            r_iwait  <= w_iwait_nxt;
            r_dload  <= w_dload_nxt;
            r_iload  <= w_iload_nxt;
            r_req    <= w_req_nxt;
            r_wen    <= w_wen_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_err    <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_last_d_nxt = r_last_d;
        w_dload_nxt  = r_dload;
        w_iload_nxt  = r_iload;
        w_req_nxt    = r_req;
        w_wen_nxt    = r_wen;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_err_nxt    = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_state_nxt  = DSERV;
                    w_cnt_nxt    = '0;
                    w_last_d_nxt = 1'b1;
                    w_req_nxt    = 1'b1;
                    w_wen_nxt    = dWEN;
                    w_addr_nxt   = daddr;
                    w_wdata_nxt  = dstore;
                end else if (w_grant_i) begin
                    w_state_nxt  = ISERV;
                    w_cnt_nxt    = '0;
                    w_last_d_nxt = 1'b0;
                    w_req_nxt    = 1'b1;
                    w_wen_nxt    = 1'b0;
                    w_addr_nxt   = iaddr;
                    w_wdata_nxt  = '0;
                end
            end
            DSERV, ISERV: begin
                if (ram_ack || w_tmo) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = (r_state == DSERV) ? DRESP : IRESP;
                    if (!ram_ack) begin
                        w_err_nxt = 1'b1;
                    end
                    // A timed-out read returns all-ones.
                    if (!r_wen) begin
                        if (r_state == DSERV) begin
                            w_dload_nxt = ram_ack ? ram_rdata : '1;
                        end else begin
                            w_iload_nxt = ram_ack ? ram_rdata : '1;
                        end
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            DRESP, IRESP: w_state_nxt = IDLE;
            default:      w_state_nxt = IDLE;
        endcase
        w_dwait_nxt = (w_state_nxt != DRESP);
        w_iwait_nxt = (w_state_nxt != IRESP);
    end

    assign dwait     = r_dwait;
    assign iwait     = r_iwait;
    assign dload     = r_dload;
    assign iload     = r_iload;
    assign ram_req   = r_req;
    assign ram_wen   = r_wen;
    assign ram_addr  = r_addr;
    assign ram_wdata = r_wdata;
    assign err       = r_err;

endmodule
